// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Receive-side controller for the serial link into the processor.
//   Synchronizes the asynchronous serial line, detects and qualifies start
//   bits, samples a 10-bit frame (start, DATA_BITS data LSB-first, stop),
//   and hands each character over through a valid/ack handshake. Framing
//   errors are reported as a one-cycle pulse; lost characters set a sticky
//   overrun flag that is cleared by the next ack.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (even, >= 4)
//   DATA_BITS     data bits per frame
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   rx_in        asynchronous serial line, idle high
//   char_ack     processor accepts current char (only honoured while char_valid)
//   char_data    last accepted character, LSB = first data bit received
//   char_valid   char_data holds an unconsumed character
//   framing_err  one-cycle pulse: stop bit sampled low
//   overrun_err  sticky: a character was dropped because char_valid was high
//   busy         receiver FSM is not idle
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 char_ack,
  output logic [DATA_BITS-1:0] char_data,
  output logic                 char_valid,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bidx, bidx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 sync1, sync2;
  logic                 rx_s;
  logic                 deliver;
  logic                 frame_bad;

  // Two-flop synchronizer; reset to the idle (high) line level so a reset
  // never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_in;
      sync2 <= sync1;
    end
  end

  assign rx_s = sync2;

  // State and bit-timing registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bidx  <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bidx  <= bidx_n;
      sh    <= sh_n;
    end
  end

  // Next-state, bit timing and frame-end decisions
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bidx_n    = bidx;
    sh_n      = sh;
    deliver   = 1'b0;
    frame_bad = 1'b0;

    case (state)
      IDLE: begin
        cnt_n  = '0;
        bidx_n = '0;
        if (!rx_s) begin
          state_n = START;
        end
      end

      START: begin
        // Re-check the line at mid start bit; a high line was a glitch.
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n  = '0;
          // Right shift: the first data bit received ends up at the LSB.
          sh_n   = {rx_s, sh[DATA_BITS-1:1]};
          bidx_n = bidx + 1'b1;
          if (bidx == LAST_BIT) begin
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) begin
            deliver = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // Processor handshake. A delivery while a character is still pending keeps
  // the oldest character unless it is being acked in the very same cycle,
  // in which case the new character replaces it and valid stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      char_data   <= '0;
      char_valid  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      framing_err <= frame_bad;
      if (deliver) begin
        if (!char_valid) begin
          char_data  <= sh;
          char_valid <= 1'b1;
        end else if (char_ack) begin
          char_data   <= sh;
          overrun_err <= 1'b0;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (char_valid && char_ack) begin
        char_valid  <= 1'b0;
        overrun_err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the serial link into the NIOS II processor. It synchronizes the incoming serial line and detects start bits. It sequences the bit-sample timing and bit-ID counting across a 10-bit frame (start, 8 data LSB-first, stop), assembles the character and hands it to the processor through a valid/ack handshake. It also flags framing and overrun errors.

## Interface
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and ≥ 4; N below
- DATA_BITS, 8, data bits per frame; char_data width
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rx_in  input  1  asynchronous serial line, idle high
- char_ack  input  1  processor accepts current char; sampled only while char_valid=1
- char_data  output  DATA_BITS  last accepted character, LSB = first data bit received
- char_valid  output  1  char_data holds an unconsumed character
- framing_err  output  1  one-cycle pulse: stop bit sampled low
- overrun_err  output  1  sticky: a character was lost because char_valid was still high
- busy  output  1  high whenever FSM is not in IDLE

## Operation
- rx_in passes through a 2-flop synchronizer (both flops reset to 1); rx_s = second flop. FSM uses only rx_s.
- Internal counters: sample counter cnt (width clog2(N)), bit index bidx (0..DATA_BITS), shift register sh.
- States: IDLE, START, DATA, STOP.
- IDLE: cnt=0, bidx=0. On rx_s=0 -> START.
- START: cnt increments each cycle. When cnt=N/2-1, check rx_s: 1 -> IDLE (false start, no outputs change); 0 -> DATA with cnt=0.
- DATA: cnt increments. At cnt=N-1, shift rx_s in at MSB (right shift, so first bit ends at LSB), bidx+1, cnt=0. After the DATA_BITS-th sample -> STOP.
- STOP: cnt increments. At cnt=N-1, sample rx_s:
  - 1: deliver sh (see handshake) -> IDLE.
  - 0: framing_err=1 for exactly one cycle, character discarded, overrun untouched -> IDLE. A held-low line (break) retriggers START and repeats framing errors per frame time.
- Handshake/delivery:
  - Delivery with char_valid=0: char_data<=sh, char_valid<=1.
  - char_ack=1 while char_valid=1: char_valid<=0, overrun_err<=0. char_ack while char_valid=0 is ignored.
  - Delivery with char_valid=1 and no ack that cycle: char_data unchanged (oldest kept), new char dropped, overrun_err<=1.
  - Delivery and ack in the same cycle: char_data<=sh, char_valid stays 1, overrun_err<=0.
- char_valid holds indefinitely until acked; char_data is stable while char_valid=1 except under the same-cycle case.
- busy is combinational from state (state≠IDLE).
- Reset mid-frame: FSM -> IDLE, counters cleared, partial character discarded. The next frame after rst deasserts is received normally.

## Timing
- Reset values: char_data=0, char_valid=0, framing_err=0, overrun_err=0, busy=0, sync flops=1, state=IDLE.
- Let E0 be the first rising edge sampling rx_in=0. rx_s=0 after E1; START is entered at E2.
- Start check occurs at E(2+N/2). Data bit i (0-based) is sampled at E(2+N/2+N(i+1)). Stop is sampled at E(2+N/2+N(DATA_BITS+1)).
- With defaults, stop is sampled at E154. char_valid or framing_err is high in the cycle after E154. busy falls after E154.
- With ideal input, samples fall 2 cycles after bit centre (synchronizer lag). This is accepted.
- Back-to-back frames: the next start bit may be detected on the first cycle in IDLE, with no idle gap required.
- Ack -> char_valid low one cycle after the edge sampling char_ack=1.

## Test plan
- Reset, then frame 0xA5 (line: 0, 1,0,1,0,0,1,0,1, 1) at N=16 -> char_data=0xA5, char_valid rises after E154 and holds 50 cycles. Ack pulse -> char_valid=0 next cycle, no errors.
- rx_in low 4 cycles then high -> busy for ~N/2 cycles, back to IDLE, char_valid=0, no errors.
- Frame 0x3C with stop bit 0 -> framing_err high exactly one cycle after E154, char_valid stays 0, char_data unchanged.
- Frames 0x11 then 0x22 back-to-back, no ack -> char_data=0x11, overrun_err=1 after second stop. Ack -> char_valid=0, overrun_err=0.
- Frame 0x11 unacked, then ack asserted on the exact cycle 0x22's stop is sampled -> char_data=0x22, char_valid=1, overrun_err=0.
- rst pulsed during data bit 4 -> all outputs at reset values next cycle. Following frame 0x5A -> char_data=0x5A, valid, no errors.
